// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types: FSM encoding for the bit-serial subtractor and the default datapath width.
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit position has to borrow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial a - b - bin: one bit per cycle, result valid WIDTH+1 cycles after accept.
// Accepts only in IDLE; result is held in DONE until out_ready.
module serial_subtractor_8bit
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             fs_d, fs_bo;

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    brw_d     = brw_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    amsb_d    = amsb_q;
    bmsb_d    = bmsb_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = fs_bo;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        // diff/bout/ovf only change here, so they stay stable through DONE and IDLE
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = res_d;
          bout_d  = fs_bo;
          ovf_d   = (amsb_q ^ bmsb_q) & (fs_d ^ amsb_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed table, corner sequences, random scoreboard run.
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rand_rdy = 1'b0;
  logic [9:0] sb[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;
  vec_t vecs[8];

  serial_subtractor_8bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference over 9 bits: bit 8 of the wrapped difference is the unsigned borrow.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] w;
    w = {1'b0, x} - {1'b0, y} - {8'd0, bi};
    return {w[7:0], w[8], (x[7] != y[7]) && (w[7] != x[7])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample handshakes at negedge, advance to 1ns after the next posedge.
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(a, b, bin));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("scoreboard", {diff, bout, ovf}, e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present operands, wait (bounded) for acceptance; acc = cycle of the handshake.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic bi, output int acc);
    int n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    bin = bi;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 1, 0);
    acc = cyc;
    tick();
  endtask

  task automatic wait_out(input int acc, output int lat);
    while (!out_valid && (cyc - acc) < 40) tick();
    lat = cyc - acc;
  endtask

  initial begin
    int acc, acc2, lat, n;
    logic busy;

    vecs[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h0A, 8'h03, 1'b0, 8'h07, 1'b0, 1'b0};

    #2 rst = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    chk("reset_ovf", ovf, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed table with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bi, acc);
      in_valid = 1'b0;
      wait_out(acc, lat);
      chk($sformatf("latency_%0d", i), lat, 9);
      chk($sformatf("vec_%0d", i), {diff, bout, ovf}, {vecs[i].d, vecs[i].bo, vecs[i].ov});
      tick();
      chk($sformatf("idle_after_%0d", i), {in_ready, out_valid}, 2'b10);
    end

    // Backpressure in DONE plus ignored in_valid during CALC.
    out_ready = 1'b0;
    send(8'h50, 8'h30, 1'b0, acc);
    in_valid = 1'b0;
    busy = 1'b0;
    for (int i = 1; i < 9 && !out_valid; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        bin = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      busy = busy | in_ready;
      tick();
    end
    chk("busy_in_ready", busy, 0);
    chk("bp_out_valid_reached", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_%0d", i), {out_valid, in_ready, diff, bout, ovf}, {1'b1, 1'b0, 8'h20, 1'b0, 1'b0});
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_idle", {in_ready, out_valid}, 2'b10);

    // Reset on the fourth CALC cycle.
    send(8'hA5, 8'h3C, 1'b0, acc);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {in_ready, out_valid, diff, bout, ovf}, {1'b1, 1'b0, 10'd0});
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      busy = busy | out_valid;
      tick();
    end
    chk("midreset_no_pulse", busy, 0);
    send(8'h0A, 8'h03, 1'b0, acc);
    in_valid = 1'b0;
    wait_out(acc, lat);
    chk("post_reset_result", {diff, bout, ovf}, {8'h07, 1'b0, 1'b0});
    tick();

    // Back-to-back with in_valid held high: WIDTH+2 cycle period.
    send(8'h12, 8'h34, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      send(8'h40 + 8'(i), 8'h11, 1'b1, acc2);
      chk($sformatf("b2b_period_%0d", i), acc2 - acc, 10);
      acc = acc2;
    end
    in_valid = 1'b0;
    wait_out(acc, lat);
    tick();

    // Random operands with random out_ready stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), acc);
      if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
